// File: rtl/alu_74382_slice_seq.sv
// alu_74382_slice_seq: walks a wide operation through an external
// combinational 74382-style ALU slice, one OPERAND_W-bit slice per cycle,
// LSB slice first. Carry ripples between slices through carry_q.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds the res_zero output.
module alu_74382_slice_seq #(
  parameter int OPERAND_W = 4,
  parameter int SLICES    = 4,
  parameter int CNT_W     = (SLICES > 1) ? $clog2(SLICES) : 1,
  localparam int DATA_W   = OPERAND_W * SLICES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_sel,
  input  logic [DATA_W-1:0]    req_a,
  input  logic [DATA_W-1:0]    req_b,
  input  logic                 req_carry_in,
  output logic [2:0]           alu_sel,
  output logic                 alu_carry_in,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  input  logic [OPERAND_W-1:0] alu_result,
  input  logic                 alu_carry_out,
  input  logic                 alu_overflow,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                 res_zero,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic                 res_carry,
  output logic                 res_overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Latched request; operands kept as slice arrays so the counter indexes directly.
  typedef struct packed {
    logic [2:0]                         sel;
    logic [SLICES-1:0][OPERAND_W-1:0]   a;
    logic [SLICES-1:0][OPERAND_W-1:0]   b;
  } op_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  state_t                           state;
  op_t                              op_q;
  logic [CNT_W-1:0]                 cnt;
  logic                             carry_q;
  logic [SLICES-1:0][OPERAND_W-1:0] res_q;

  assign res_data = res_q;

  // Sequencer FSM: accept, ripple through slices, hold result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      res_valid    <= 1'b0;
      res_q        <= '0;
      res_carry    <= 1'b0;
      res_overflow <= 1'b0;
      cnt          <= '0;
      carry_q      <= 1'b0;
      op_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q.sel  <= req_sel;
            op_q.a    <= req_a;
            op_q.b    <= req_b;
            carry_q   <= req_carry_in;
            cnt       <= '0;
            req_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_q[cnt] <= alu_result;
          carry_q    <= alu_carry_out;
          if (cnt == LAST) begin
            res_carry    <= alu_carry_out;
            res_overflow <= alu_overflow;
            res_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive: only the active slice during RUN, quiet zeros otherwise.
  always_comb begin
    alu_sel      = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;
    if (state == RUN) begin
      alu_sel      = op_q.sel;
      alu_a        = op_q.a[cnt];
      alu_b        = op_q.b[cnt];
      alu_carry_in = carry_q;
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic nz_q;

  // OR-accumulate slice results; zero flag resolved on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      nz_q     <= 1'b0;
      res_zero <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      nz_q <= 1'b0;
    end else if (state == RUN) begin
      nz_q <= nz_q | (|alu_result);
      if (cnt == LAST) res_zero <= ~(nz_q | (|alu_result));
    end
  end
`endif

endmodule

// File: tb/tb_alu_74382_slice_seq.sv
// Directed bench for alu_74382_slice_seq with a behavioural 74382 slice
// wired around it. Inputs driven and outputs sampled on the falling edge.
module tb_alu_74382_slice_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_sel;
  logic [15:0] req_a, req_b;
  logic        req_carry_in;
  logic [2:0]  alu_sel;
  logic        alu_carry_in;
  logic [3:0]  alu_a, alu_b, alu_result;
  logic        alu_carry_out, alu_overflow;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_carry, res_overflow;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        res_zero;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] a_seq [4];
  logic [3:0] b_seq [4];
  logic       c_seq [4];

  always #5 clk = ~clk;

  alu_74382_slice_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .req_carry_in(req_carry_in),
    .alu_sel(alu_sel), .alu_carry_in(alu_carry_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_overflow(res_overflow)
  );

  // Behavioural 74382 slice: arithmetic codes produce carry/overflow, others report 0.
  logic [3:0] mx, my;
  logic [4:0] msum;
  always @* begin
    mx = alu_a;
    my = alu_b;
    if (alu_sel == 3'b001) mx = ~alu_a;
    if (alu_sel == 3'b010) my = ~alu_b;
    msum = {1'b0, mx} + {1'b0, my} + {4'b0, alu_carry_in};
    alu_result    = 4'h0;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_sel)
      3'b000: alu_result = 4'h0;
      3'b001, 3'b010, 3'b011: begin
        alu_result    = msum[3:0];
        alu_carry_out = msum[4];
        alu_overflow  = (mx[3] == my[3]) && (msum[3] != mx[3]);
      end
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = alu_a | alu_b;
      3'b110: alu_result = alu_a & alu_b;
      default: alu_result = 4'hF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enter at a falling edge in IDLE; return at the falling edge where res_valid should be up.
  task automatic run_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                        input logic ci);
    req_sel = s; req_a = a; req_b = b; req_carry_in = ci; req_valid = 1'b1;
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("run_alu_sel", {29'b0, alu_sel}, {29'b0, s});
    for (int i = 0; i < 4; i++) begin
      a_seq[i] = alu_a;
      b_seq[i] = alu_b;
      c_seq[i] = alu_carry_in;
      chk("run_not_valid", {31'b0, res_valid}, 32'd0);
      chk("run_not_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("latency_valid", {31'b0, res_valid}, 32'd1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_valid_low", {31'b0, res_valid}, 32'd0);
    chk("release_ready_high", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] d, input logic c, input logic o);
    chk({tag, "_data"}, {16'b0, res_data}, {16'b0, d});
    chk({tag, "_carry"}, {31'b0, res_carry}, {31'b0, c});
    chk({tag, "_ovf"}, {31'b0, res_overflow}, {31'b0, o});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_sel = '0; req_a = '0; req_b = '0; req_carry_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0);
    chk("rst_alu_a", {28'b0, alu_a}, 32'd0);
    chk("rst_alu_sel", {29'b0, alu_sel}, 32'd0);
    chk("rst_alu_cin", {31'b0, alu_carry_in}, 32'd0);
    rst = 1'b0;

    // carry across slice 1 -> 2
    run_op(3'b011, 16'h00FF, 16'h0001, 1'b0);
    chk_res("add_00ff", 16'h0100, 1'b0, 1'b0);
    release_res();

    // full ripple, all-zero result
    run_op(3'b011, 16'hFFFF, 16'h0001, 1'b0);
    chk_res("add_ffff", 16'h0000, 1'b1, 1'b0);
    chk("ripple_cin0", {31'b0, c_seq[0]}, 32'd0);
    chk("ripple_cin1", {31'b0, c_seq[1]}, 32'd1);
    chk("ripple_cin2", {31'b0, c_seq[2]}, 32'd1);
    chk("ripple_cin3", {31'b0, c_seq[3]}, 32'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("zero_set", {31'b0, res_zero}, 32'd1);
`endif
    release_res();

    // signed overflow on top slice
    run_op(3'b011, 16'h7FFF, 16'h0001, 1'b0);
    chk_res("add_ovf", 16'h8000, 1'b0, 1'b1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("zero_clr", {31'b0, res_zero}, 32'd0);
`endif
    release_res();

    // A-B with carry-in 1 (no borrow)
    run_op(3'b010, 16'h1234, 16'h0234, 1'b1);
    chk_res("sub_ab", 16'h1000, 1'b1, 1'b0);
    release_res();

    // B-A
    run_op(3'b001, 16'h0001, 16'h0003, 1'b1);
    chk_res("sub_ba", 16'h0002, 1'b1, 1'b0);
    release_res();

    // xor plus slice ordering on the ALU bus
    run_op(3'b100, 16'hF0F0, 16'hFF00, 1'b0);
    chk_res("xor", 16'h0FF0, 1'b0, 1'b0);
    chk("xor_a_seq", {16'b0, a_seq[3], a_seq[2], a_seq[1], a_seq[0]}, 32'h0000F0F0);
    chk("xor_b_seq", {16'b0, b_seq[3], b_seq[2], b_seq[1], b_seq[0]}, 32'h0000FF00);
    release_res();

    // preset and clear
    run_op(3'b111, 16'h1234, 16'h5678, 1'b0);
    chk("preset_data", {16'b0, res_data}, 32'h0000FFFF);
    release_res();
    run_op(3'b000, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("clear_data", {16'b0, res_data}, 32'h00000000);
    release_res();

    // backpressure in DONE with a pending request
    run_op(3'b101, 16'h1200, 16'h0034, 1'b0);
    req_sel = 3'b110; req_a = 16'hFFFF; req_b = 16'h00F0; req_carry_in = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("hold_data", {16'b0, res_data}, 32'h00001234);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      @(negedge clk);
    end
    release_res();
    run_op(3'b110, 16'hFFFF, 16'h00F0, 1'b0);
    chk_res("and_after_hold", 16'h00F0, 1'b0, 1'b0);
    release_res();

    // reset in the middle of RUN
    req_sel = 3'b011; req_a = 16'hABCD; req_b = 16'h1111; req_carry_in = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_slice2_a", {28'b0, alu_a}, 32'hB);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_valid", {31'b0, res_valid}, 32'd0);
    chk("midrst_data", {16'b0, res_data}, 32'd0);
    chk("midrst_alu_a", {28'b0, alu_a}, 32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_no_emit", {31'b0, res_valid}, 32'd0);
    run_op(3'b011, 16'h0001, 16'h0001, 1'b0);
    chk_res("after_rst", 16'h0002, 1'b0, 1'b0);
    release_res();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
